// File: rtl/text_overlay_ctrl_pkg.sv
// Shared types and constants for the text overlay controller:
// debounce FSM states, text box geometry, reset filter selection.
package text_overlay_ctrl_pkg;

    typedef enum logic [1:0] {
        STABLE  = 2'd0,
        COUNT   = 2'd1,
        PENDING = 2'd2
    } deb_state_t;

    localparam int TEXT_CHARS = 30;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int BOX_W      = TEXT_CHARS * GLYPH_W;

    localparam logic [3:0] SEL_RESET = 4'b0111;

    // One pixel's worth of timing plus background colour, carried down the pipeline.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

endpackage

// File: rtl/text_overlay_ctrl_sel_debounce.sv
// Synchronises and debounces the filter-select switches; a settled value is
// committed to sel only on a vblank rising edge so a frame is never torn.
module sel_debounce
    import text_overlay_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       vblnk_in,
    output logic [3:0] sel
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_swMeta;
    logic [3:0]       r_swSync;
    logic             r_vblnkPrev;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_cand;
    logic [3:0]       r_sel;

    deb_state_t       w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [3:0]       w_candNext;
    logic [3:0]       w_selNext;
    logic             w_vblnkRise;

    assign w_vblnkRise = vblnk_in & ~r_vblnkPrev;
    assign sel         = r_sel;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_swMeta    <= SEL_RESET;
            r_swSync    <= SEL_RESET;
            r_vblnkPrev <= 1'b0;
            r_state     <= STABLE;
            r_cnt       <= '0;
            r_cand      <= SEL_RESET;
            r_sel       <= SEL_RESET;
        end else begin
            r_swMeta    <= sw;
            r_swSync    <= r_swMeta;
            r_vblnkPrev <= vblnk_in;
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_cand      <= w_candNext;
            r_sel       <= w_selNext;
        end
    end

    // r_cand tracks the value being timed; a different synchronised value restarts the count.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_candNext  = r_cand;
        w_selNext   = r_sel;
        case (r_state)
            STABLE: begin
                if (r_swSync != r_sel) begin
                    w_stateNext = COUNT;
                    w_cntNext   = '0;
                    w_candNext  = r_swSync;
                end
            end
            COUNT: begin
                if (r_swSync == r_sel) begin
                    w_stateNext = STABLE;
                    w_cntNext   = '0;
                end else if (r_swSync != r_cand) begin
                    w_cntNext  = '0;
                    w_candNext = r_swSync;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = PENDING;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
            end
            PENDING: begin
                if (r_swSync != r_cand) begin
                    w_stateNext = COUNT;
                    w_cntNext   = '0;
                    w_candNext  = r_swSync;
                end else if (w_vblnkRise) begin
                    w_stateNext = STABLE;
                    w_cntNext   = '0;
                    w_selNext   = r_cand;
                end
            end
            default: begin
                w_stateNext = STABLE;
                w_cntNext   = '0;
            end
        endcase
    end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Three-stage pixel pipeline that overlays a 30x1 character text box on the
// incoming video, plus the debounced filter-select register.
module text_overlay_ctrl
    import text_overlay_ctrl_pkg::*;
#(
    parameter int          TEXT_X          = 16,
    parameter int          TEXT_Y          = 16,
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [11:0] TEXT_RGB        = 12'hFFF
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [3:0]  sw,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [3:0]  sel,
    output logic [4:0]  char_xy,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_line,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [10:0] BOX_X0 = 11'(TEXT_X);
    localparam logic [10:0] BOX_Y0 = 11'(TEXT_Y);
    localparam logic [10:0] BOX_WL = 11'(BOX_W);
    localparam logic [10:0] BOX_HL = 11'(GLYPH_H);

    pix_t        w_pixIn;
    logic [10:0] w_hOff;
    logic [10:0] w_vOff;
    logic        w_inBox;

    pix_t        r_pix1, r_pix2, r_pix3;
    logic [4:0]  r_charXy;
    logic [3:0]  r_row1;
    logic [2:0]  r_bit1, r_bit2, r_bit3;
    logic        r_inBox1, r_inBox2, r_inBox3;
    logic [10:0] r_fontAddr;

    sel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .pclk    (pclk),
        .rst_n   (rst_n),
        .sw      (sw),
        .vblnk_in(vblnk_in),
        .sel     (sel)
    );

    assign w_pixIn = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    // Offsets wrap to large values left of / above the box, so one compare per axis suffices.
    assign w_hOff  = hcount_in - BOX_X0;
    assign w_vOff  = vcount_in - BOX_Y0;
    assign w_inBox = (w_hOff < BOX_WL) && (w_vOff < BOX_HL);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix1     <= '0;
            r_pix2     <= '0;
            r_pix3     <= '0;
            r_charXy   <= '0;
            r_row1     <= '0;
            r_bit1     <= '0;
            r_bit2     <= '0;
            r_bit3     <= '0;
            r_inBox1   <= 1'b0;
            r_inBox2   <= 1'b0;
            r_inBox3   <= 1'b0;
            r_fontAddr <= '0;
        end else begin
            r_pix1     <= w_pixIn;
            r_charXy   <= w_inBox ? w_hOff[7:3] : 5'd0;
            r_row1     <= w_vOff[3:0];
            r_bit1     <= w_hOff[2:0];
            r_inBox1   <= w_inBox;

            r_pix2     <= r_pix1;
            r_fontAddr <= {char_code, r_row1};
            r_bit2     <= r_bit1;
            r_inBox2   <= r_inBox1;

            r_pix3     <= r_pix2;
            r_bit3     <= r_bit2;
            r_inBox3   <= r_inBox2;
        end
    end

    assign char_xy    = r_charXy;
    assign font_addr  = r_fontAddr;
    assign hcount_out = r_pix3.hcount;
    assign vcount_out = r_pix3.vcount;
    assign hsync_out  = r_pix3.hsync;
    assign vsync_out  = r_pix3.vsync;
    assign hblnk_out  = r_pix3.hblnk;
    assign vblnk_out  = r_pix3.vblnk;

    // font_line is already registered inside the ROM, so stage 3 only muxes it against stage-3 state.
    always_comb begin
        rgb_out = r_pix3.rgb;
        if (r_pix3.hblnk || r_pix3.vblnk) begin
            rgb_out = 12'h000;
        end else if (r_inBox3 && font_line[3'd7 - r_bit3]) begin
            rgb_out = TEXT_RGB;
        end
    end

endmodule

// File: doc/text_overlay_ctrl.md
TEXT_OVERLAY_CTRL -- requirements
Module: text_overlay_ctrl

Interface
REQ-001 Parameter TEXT_X, default 16: pixel column of the text box's left edge.
REQ-002 Parameter TEXT_Y, default 16: pixel row of the text box's top edge.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000: number of stable pclk cycles required before a switch change is accepted.
REQ-004 Parameter TEXT_RGB, default 12'hFFF: colour of lit glyph pixels.
REQ-005 The block SHALL have the following ports; clock and reset are listed first.
- pclk, in, 1: pixel clock, the single clock domain.
- rst_n, in, 1: reset, asynchronous, active-low.
- sw, in, 4: raw filter-select switches, asynchronous to pclk.
- hcount_in, vcount_in, in, 11 each: timing counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in, in, 1 each: timing strobes.
- rgb_in, in, 12: background pixel.
- sel, out, 4: committed filter selection, fed to the filter datapath and to the text ROM.
- char_xy, out, 5: character index 0..29, to the text ROM.
- char_code, in, 7: ASCII code from the text ROM, combinational from char_xy and sel.
- font_addr, out, 11: font ROM address, {char_code, glyph_row[3:0]}.
- font_line, in, 8: font ROM row data, valid 1 cycle after font_addr (registered ROM); bit 7 is the leftmost pixel.
- hcount_out, vcount_out, out, 11 each: delayed timing counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out, out, 1 each: delayed timing strobes.
- rgb_out, out, 12: output pixel.

Function
REQ-006 Text box: 30 characters × 8 px wide (240 px) × 16 rows; in_box = hcount in [TEXT_X, TEXT_X+239] and vcount in [TEXT_Y, TEXT_Y+15].
REQ-007 Stage 1 SHALL register all timing inputs and rgb_in, and SHALL drive char_xy = (hcount_in − TEXT_X)[7:3] registered; char_xy SHALL be 0 when outside the box.
REQ-008 Stage 2 SHALL register font_addr = {char_code, (vcount − TEXT_Y)[3:0]}, the in_box flag, and bit index (hcount − TEXT_X)[2:0].
REQ-009 Stage 3 SHALL output rgb_out = TEXT_RGB when in_box and font_line[7 − bit index] = 1; otherwise rgb_out = delayed rgb_in.
REQ-010 rgb_out SHALL be 12'h000 whenever delayed hblnk or vblnk is 1, overriding REQ-009.
REQ-011 All *_out timing signals and rgb_out SHALL have a fixed latency of exactly 3 pclk cycles relative to the inputs.
REQ-012 sw SHALL pass through a 2-FF synchronizer before use.
REQ-013 The debounce FSM SHALL have the states STABLE, COUNT and PENDING.
- STABLE → COUNT when the synchronized sw ≠ sel; the counter is cleared on entry.
- COUNT: counter increments each cycle; any change of sync sw restarts the count from 0.
- COUNT → STABLE when sync sw = sel again.
- COUNT → PENDING when the counter reaches DEBOUNCE_CYCLES−1; the candidate value is latched on this transition.
- PENDING → STABLE on the rising edge of vblnk_in, with sel ← candidate in that same cycle.
REQ-014 While in PENDING, a further sw change SHALL discard the candidate and return the FSM to COUNT.
REQ-015 sel SHALL change only on a vblnk_in rising edge, so the frame is never torn.
REQ-016 A vblnk rising edge coinciding with the COUNT→PENDING transition SHALL NOT commit; the commit waits for the next vblank.
REQ-017 The counter width SHALL be $clog2(DEBOUNCE_CYCLES), and the counter SHALL saturate, never wrapping.

Reset
REQ-018 While rst_n = 0, the following SHALL hold:
- sel = 4'b0111 (original image).
- FSM = STABLE, counter = 0.
- All pipeline registers, *_out, char_xy, font_addr and rgb_out = 0.
- Synchronizer flops = 4'b0111.
REQ-019 Reset assertion mid-frame or mid-debounce SHALL take effect immediately (asynchronous) and SHALL discard any pending candidate.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, the text box constants (30 chars, 8×16 glyph) and the reset selection 4'b0111.
REQ-021 The debounce/commit FSM SHALL be a sub-module sel_debounce; the pixel pipeline SHALL live in the top module.

Verification
REQ-022 Run the bench with DEBOUNCE_CYCLES = 16 and TEXT_X = TEXT_Y = 16, and cover these directed scenarios:
- Reset released → sel = 4'b0111; after 3 cycles *_out match the inputs delayed by 3, and rgb_out = 0 during blanking.
- sw = 4'b0011 held 16 cycles mid-frame → sel stays 7 until the next vblnk rise, then sel = 3 in that cycle.
- sw toggling 0011/0100 every 10 cycles for 200 cycles → sel never changes.
- hcount = 16+8·5+2, vcount = 16+3, char_code = 'R', font_line = 8'b00100000 → char_xy = 5; font_addr = {7'h52, 4'h3} at stage 2; rgb_out = 12'hFFF 3 cycles after the input.
- Pixel at hcount = 256 (outside the box), rgb_in = 12'h0A5 → rgb_out = 12'h0A5 3 cycles later, and char_xy = 0.
- rst_n pulsed low while in PENDING with candidate 9 → sel = 7, FSM = STABLE, and no commit at the next vblank.
